// File: rtl/mcu_rom_loader_if.sv
// PSRAM write-side bus and loader status produced by mcu_rom_loader.
// The master side is the loader; the slave side is the top-level pin mux
// that substitutes these signals for the mapper's pass-through while loading.
interface mcu_rom_loader_if;
  logic [22:0] mem_a;
  logic [7:0]  mem_d;
  logic        prg_ce;
  logic        prg_we;
  logic        chr_ce;
  logic        chr_we;
  logic        loading;
  logic        err;

  modport master (
    output mem_a, mem_d, prg_ce, prg_we, chr_ce, chr_we, loading, err
  );

  modport slave (
    input  mem_a, mem_d, prg_ce, prg_we, chr_ce, chr_we, loading, err
  );
endinterface

// File: rtl/mcu_rom_loader.sv
// SPI-slave (mode 0, MSB first) ROM loader. Receives a command byte, a
// 24-bit start address and a stream of data bytes from the MCU and writes
// each data byte into the PRG or CHR PSRAM low byte lane with a fixed-width
// write strobe. A status command returns {6'b0, err, loading}.
module mcu_rom_loader #(
  parameter int unsigned WE_CYCLES   = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk50,
  input  logic             rst,
  input  logic             mcu_clk,
  input  logic             mcu_mosi,
  input  logic             mcu_ss,
  output logic             mcu_miso,
  mcu_rom_loader_if.master mem
);

  localparam int unsigned WCW = $clog2(WE_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_ADDR2,
    S_ADDR1,
    S_ADDR0,
    S_DATA,
    S_WRITE,
    S_RECOVER,
    S_STAT,
    S_IGNORE
  } state_t;

  // synchronisers
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic                   sck_prev_q, sck_prev_d;

  // framing and shift registers
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shreg_q, shreg_d;
  logic [7:0]  tx_q, tx_d;

  // FSM and datapath
  state_t      state_q, state_d;
  logic [14:0] addr_hi_q, addr_hi_d;
  logic [22:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_d_q, mem_d_d;
  logic        tgt_chr_q, tgt_chr_d;
  logic [WCW-1:0] we_cnt_q, we_cnt_d;
  logic        abort_q, abort_d;
  logic        loading_q, loading_d;
  logic        err_q, err_d;
  logic        prg_ce_q, prg_ce_d;
  logic        prg_we_q, prg_we_d;
  logic        chr_ce_q, chr_ce_d;
  logic        chr_we_q, chr_we_d;

  // combinational helpers
  logic        sck_s, mosi_s, ss_s;
  logic        sck_rise, sck_fall;
  logic        byte_done;
  logic [7:0]  rx_byte;
  logic        strobe_d;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign rx_byte  = {shreg_q, mosi_s};

  // Next state of the input synchroniser chains and SCK edge history.
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], mcu_clk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mcu_mosi};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], mcu_ss};
    sck_prev_d  = sck_s;
  end

  // Byte framing, status shift-out, command/address/write sequencing.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
    state_d   = state_q;
    addr_hi_d = addr_hi_q;
    mem_a_d   = mem_a_q;
    mem_d_d   = mem_d_q;
    tgt_chr_d = tgt_chr_q;
    we_cnt_d  = we_cnt_q;
    abort_d   = abort_q;
    loading_d = loading_q;
    err_d     = err_q;
    strobe_d  = 1'b0;
    byte_done = 1'b0;

    // A deasserted select discards any partial byte.
    if (ss_s) begin
      bit_cnt_d = '0;
    end else if (sck_rise) begin
      shreg_d   = rx_byte[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      byte_done = (bit_cnt_q == 3'd7);
    end

    // Status bits move on falling SCK, but not on the falling edge that
    // closes the command byte: bit 7 must stay up for the first rising edge.
    if (state_q == S_STAT && !ss_s && sck_fall && bit_cnt_q != 3'd0) begin
      tx_d = {tx_q[6:0], 1'b0};
    end

    unique case (state_q)
      S_IDLE: begin
        if (!ss_s) state_d = S_CMD;
      end
      S_CMD: begin
        if (byte_done) begin
          unique case (rx_byte)
            8'h01: begin
              tgt_chr_d = 1'b0;
              loading_d = 1'b1;
              state_d   = S_ADDR2;
            end
            8'h02: begin
              tgt_chr_d = 1'b1;
              loading_d = 1'b1;
              state_d   = S_ADDR2;
            end
            8'h00: begin
              tx_d    = {6'b0, err_q, loading_q};
              state_d = S_STAT;
            end
            default: state_d = S_IGNORE;
          endcase
        end
      end
      S_ADDR2: begin
        // Bit 23 of the address is dropped; the PSRAM space is 23 bits.
        if (byte_done) begin
          addr_hi_d = {rx_byte[6:0], 8'h00};
          state_d   = S_ADDR1;
        end
      end
      S_ADDR1: begin
        if (byte_done) begin
          addr_hi_d[7:0] = rx_byte;
          state_d        = S_ADDR0;
        end
      end
      S_ADDR0: begin
        if (byte_done) begin
          mem_a_d = {addr_hi_q, rx_byte};
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (byte_done) begin
          mem_d_d  = rx_byte;
          we_cnt_d = '0;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        // First WRITE cycle is address/data setup; strobe follows for
        // WE_CYCLES cycles. A deselect is remembered, not acted on, so the
        // strobe is never truncated.
        if (byte_done) err_d = 1'b1;
        if (ss_s) abort_d = 1'b1;
        if (we_cnt_q == WCW'(WE_CYCLES)) begin
          state_d = S_RECOVER;
        end else begin
          strobe_d = 1'b1;
          we_cnt_d = we_cnt_q + WCW'(1);
        end
      end
      S_RECOVER: begin
        if (byte_done) err_d = 1'b1;
        mem_a_d = mem_a_q + 23'd1;
        state_d = (abort_q || ss_s) ? S_IDLE : S_DATA;
      end
      S_STAT: begin
        if (byte_done) begin
          err_d = 1'b0;
          tx_d  = '0;
        end
      end
      S_IGNORE: begin
      end
      default: state_d = S_IDLE;
    endcase

    // Deselect returns to IDLE from anywhere except mid-write.
    if (ss_s && state_q != S_WRITE && state_q != S_RECOVER) begin
      state_d = S_IDLE;
    end

    if (state_d == S_IDLE) begin
      loading_d = 1'b0;
      abort_d   = 1'b0;
      tx_d      = '0;
    end

    // Only the selected target ever sees the strobe.
    prg_ce_d = ~(strobe_d & ~tgt_chr_q);
    prg_we_d = ~(strobe_d & ~tgt_chr_q);
    chr_ce_d = ~(strobe_d & tgt_chr_q);
    chr_we_d = ~(strobe_d & tgt_chr_q);
  end

  // All state, with synchronous reset abandoning any write in progress.
  always_ff @(posedge clk50) begin
    if (rst) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
      sck_prev_q  <= 1'b0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      tx_q        <= '0;
      state_q     <= S_IDLE;
      addr_hi_q   <= '0;
      mem_a_q     <= '0;
      mem_d_q     <= '0;
      tgt_chr_q   <= 1'b0;
      we_cnt_q    <= '0;
      abort_q     <= 1'b0;
      loading_q   <= 1'b0;
      err_q       <= 1'b0;
      prg_ce_q    <= 1'b1;
      prg_we_q    <= 1'b1;
      chr_ce_q    <= 1'b1;
      chr_we_q    <= 1'b1;
    end else begin
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_sync_q   <= ss_sync_d;
      sck_prev_q  <= sck_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      tx_q        <= tx_d;
      state_q     <= state_d;
      addr_hi_q   <= addr_hi_d;
      mem_a_q     <= mem_a_d;
      mem_d_q     <= mem_d_d;
      tgt_chr_q   <= tgt_chr_d;
      we_cnt_q    <= we_cnt_d;
      abort_q     <= abort_d;
      loading_q   <= loading_d;
      err_q       <= err_d;
      prg_ce_q    <= prg_ce_d;
      prg_we_q    <= prg_we_d;
      chr_ce_q    <= chr_ce_d;
      chr_we_q    <= chr_we_d;
    end
  end

  assign mcu_miso    = ss_s ? 1'bz : tx_q[7];
  assign mem.mem_a   = mem_a_q;
  assign mem.mem_d   = mem_d_q;
  assign mem.prg_ce  = prg_ce_q;
  assign mem.prg_we  = prg_we_q;
  assign mem.chr_ce  = chr_ce_q;
  assign mem.chr_we  = chr_we_q;
  assign mem.loading = loading_q;
  assign mem.err     = err_q;

endmodule

// File: tb/tb_mcu_rom_loader.sv
// Directed bench for mcu_rom_loader. Two instances share the SPI pins:
// u_dut with default strobe width, u_ovr with a 15-cycle strobe so that a
// back-to-back byte at the fastest resolvable SCK lands inside a write.
module tb_mcu_rom_loader;

  logic clk50 = 1'b0;
  logic rst   = 1'b1;
  logic sck   = 1'b0;
  logic mosi  = 1'b0;
  logic ss    = 1'b1;
  wire  miso_a, miso_b;

  mcu_rom_loader_if ia ();
  mcu_rom_loader_if ib ();

  mcu_rom_loader #(.WE_CYCLES(3), .SYNC_STAGES(2)) u_dut (
    .clk50(clk50), .rst(rst), .mcu_clk(sck), .mcu_mosi(mosi), .mcu_ss(ss),
    .mcu_miso(miso_a), .mem(ia)
  );

  mcu_rom_loader #(.WE_CYCLES(15), .SYNC_STAGES(2)) u_ovr (
    .clk50(clk50), .rst(rst), .mcu_clk(sck), .mcu_mosi(mosi), .mcu_ss(ss),
    .mcu_miso(miso_b), .mem(ib)
  );

  always #10 clk50 = ~clk50;

  typedef struct {
    bit          chr;
    int          w;
    logic [22:0] a;
    logic [7:0]  d;
  } pulse_t;

  pulse_t pq_a [$];
  pulse_t pq_b [$];
  pulse_t cur [2];
  int run [2];
  int unstable [2];
  int cewe_bad [2];
  int load_hi_a;
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Records each strobe: target, width in cycles, address/data at first low cycle.
  task automatic mon(input int k, input logic pce, input logic pwe, input logic cce,
                     input logic cwe, input logic [22:0] a, input logic [7:0] d);
    if (pce !== pwe || cce !== cwe || (pwe === 1'b0 && cwe === 1'b0)) cewe_bad[k]++;
    if (pwe === 1'b0 || cwe === 1'b0) begin
      if (run[k] == 0) begin
        cur[k].chr = (cwe === 1'b0);
        cur[k].a   = a;
        cur[k].d   = d;
      end else if (a !== cur[k].a || d !== cur[k].d) begin
        unstable[k]++;
      end
      run[k]++;
    end else if (run[k] != 0) begin
      cur[k].w = run[k];
      run[k]   = 0;
      if (k == 0) pq_a.push_back(cur[k]);
      else        pq_b.push_back(cur[k]);
    end
  endtask

  always @(negedge clk50) begin
    mon(0, ia.prg_ce, ia.prg_we, ia.chr_ce, ia.chr_we, ia.mem_a, ia.mem_d);
    mon(1, ib.prg_ce, ib.prg_we, ib.chr_ce, ib.chr_we, ib.mem_a, ib.mem_d);
    if (ia.loading === 1'b1) load_hi_a++;
  end

  task automatic chk_pulse(input string tag, input pulse_t p, input bit chr,
                           input int w, input logic [22:0] a, input logic [7:0] d);
    chk({tag, "_tgt"}, 32'(p.chr), 32'(chr));
    chk({tag, "_w"}, p.w, w);
    chk({tag, "_a"}, {9'b0, p.a}, {9'b0, a});
    chk({tag, "_d"}, {24'b0, p.d}, {24'b0, d});
  endtask

  // One SPI byte, mode 0, MSB first; 'half' is the SCK half period in clk50 cycles.
  task automatic spi_byte(input logic [7:0] tx, input int half,
                          output logic [7:0] rx_a, output logic [7:0] rx_b);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      repeat (half) @(negedge clk50);
      rx_a[i] = miso_a;
      rx_b[i] = miso_b;
      sck = 1'b1;
      repeat (half) @(negedge clk50);
      sck = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] tx, input int half);
    logic [7:0] ra, rb;
    spi_byte(tx, half, ra, rb);
  endtask

  task automatic ss_begin();
    ss = 1'b0;
    repeat (20) @(negedge clk50);
  endtask

  task automatic ss_end();
    repeat (20) @(negedge clk50);
    ss = 1'b1;
    repeat (30) @(negedge clk50);
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0]  ra, rb;
    logic [22:0] exp_a [3];
    logic [7:0]  exp_d [3];
    bit          seen;

    repeat (5) @(negedge clk50);
    rst = 1'b0;
    @(negedge clk50);

    // reset state
    chk("rst_prg_ce", ia.prg_ce, 1);
    chk("rst_prg_we", ia.prg_we, 1);
    chk("rst_chr_ce", ia.chr_ce, 1);
    chk("rst_chr_we", ia.chr_we, 1);
    chk("rst_mem_a", {9'b0, ia.mem_a}, 0);
    chk("rst_mem_d", {24'b0, ia.mem_d}, 0);
    chk("rst_loading", ia.loading, 0);
    chk("rst_err", ia.err, 0);

    // single PRG byte
    pq_a.delete();
    ss_begin();
    send(8'h01, 10);
    repeat (5) @(negedge clk50);
    chk("t1_loading_after_cmd", ia.loading, 1);
    send(8'h00, 10);
    send(8'h80, 10);
    send(8'h00, 10);
    send(8'hA5, 10);
    repeat (10) @(negedge clk50);
    chk("t1_loading_before_ss", ia.loading, 1);
    chk("t1_mem_a_inc", {9'b0, ia.mem_a}, 32'h008001);
    ss_end();
    chk("t1_loading_after_ss", ia.loading, 0);
    chk("t1_count", pq_a.size(), 1);
    if (pq_a.size() >= 1) chk_pulse("t1_p0", pq_a[0], 1'b0, 3, 23'h008000, 8'hA5);

    // CHR burst across the address wrap
    pq_a.delete();
    exp_a[0] = 23'h7FFFFE; exp_d[0] = 8'h11;
    exp_a[1] = 23'h7FFFFF; exp_d[1] = 8'h22;
    exp_a[2] = 23'h000000; exp_d[2] = 8'h33;
    ss_begin();
    send(8'h02, 10);
    send(8'h7F, 10);
    send(8'hFF, 10);
    send(8'hFE, 10);
    send(8'h11, 10);
    send(8'h22, 10);
    send(8'h33, 10);
    ss_end();
    chk("t2_count", pq_a.size(), 3);
    for (int i = 0; i < 3 && i < pq_a.size(); i++)
      chk_pulse($sformatf("t2_p%0d", i), pq_a[i], 1'b1, 3, exp_a[i], exp_d[i]);
    chk("t2_mem_a_after", {9'b0, ia.mem_a}, 32'h000001);

    // overrun: back-to-back bytes at 25 MHz SCK
    pq_a.delete();
    pq_b.delete();
    ss_begin();
    send(8'h01, 1);
    send(8'h00, 1);
    send(8'h01, 1);
    send(8'h00, 1);
    send(8'hC3, 1);
    send(8'h3C, 1);
    ss_end();
    chk("t3_ovr_count", pq_b.size(), 1);
    if (pq_b.size() >= 1) chk_pulse("t3_ovr_p0", pq_b[0], 1'b0, 15, 23'h000100, 8'hC3);
    chk("t3_ovr_err", ib.err, 1);
    chk("t3_dut_err", ia.err, 0);
    chk("t3_dut_count", pq_a.size(), 2);
    if (pq_a.size() >= 2) begin
      chk_pulse("t3_dut_p0", pq_a[0], 1'b0, 3, 23'h000100, 8'hC3);
      chk_pulse("t3_dut_p1", pq_a[1], 1'b0, 3, 23'h000101, 8'h3C);
    end

    // status read
    ss_begin();
    send(8'h00, 10);
    spi_byte(8'h00, 10, ra, rb);
    ss_end();
    chk("t3_stat_ovr", {24'b0, rb}, 32'h02);
    chk("t3_stat_dut", {24'b0, ra}, 32'h00);
    chk("t3_ovr_err_cleared", ib.err, 0);

    // deselect two cycles into a write strobe
    pq_a.delete();
    ss_begin();
    send(8'h01, 10);
    send(8'h00, 10);
    send(8'h00, 10);
    send(8'h10, 10);
    seen = 1'b0;
    fork
      send(8'h5A, 10);
      begin
        for (int i = 0; i < 400 && ia.prg_we !== 1'b0; i++) @(negedge clk50);
        seen = (ia.prg_we === 1'b0);
        chk("t4_loading_in_write", ia.loading, 1);
        repeat (2) @(negedge clk50);
        ss = 1'b1;
      end
    join
    chk("t4_we_seen", 32'(seen), 1);
    repeat (30) @(negedge clk50);
    chk("t4_count", pq_a.size(), 1);
    if (pq_a.size() >= 1) chk_pulse("t4_p0", pq_a[0], 1'b0, 3, 23'h000010, 8'h5A);
    chk("t4_loading_after", ia.loading, 0);

    // illegal command
    pq_a.delete();
    load_hi_a = 0;
    ss_begin();
    send(8'h55, 10);
    send(8'h01, 10);
    send(8'h00, 10);
    send(8'h00, 10);
    send(8'hAA, 10);
    ss_end();
    chk("t6_count", pq_a.size(), 0);
    chk("t6_loading_cycles", load_hi_a, 0);

    // reset during a write
    ss_begin();
    send(8'h01, 10);
    send(8'h00, 10);
    send(8'h02, 10);
    send(8'h00, 10);
    seen = 1'b0;
    fork
      send(8'h77, 10);
      begin
        for (int i = 0; i < 400 && ia.prg_we !== 1'b0; i++) @(negedge clk50);
        seen = (ia.prg_we === 1'b0);
        rst = 1'b1;
        @(negedge clk50);
        chk("t5_prg_ce", ia.prg_ce, 1);
        chk("t5_prg_we", ia.prg_we, 1);
        chk("t5_chr_ce", ia.chr_ce, 1);
        chk("t5_chr_we", ia.chr_we, 1);
        chk("t5_mem_a", {9'b0, ia.mem_a}, 0);
        chk("t5_loading", ia.loading, 0);
      end
    join
    chk("t5_we_seen", 32'(seen), 1);
    ss = 1'b1;
    repeat (5) @(negedge clk50);
    rst = 1'b0;
    pq_a.delete();
    pq_b.delete();
    repeat (50) @(negedge clk50);
    chk("t5_no_more_strobes", pq_a.size(), 0);
    chk("t5_mem_d", {24'b0, ia.mem_d}, 0);

    // whole-run strobe integrity
    chk("cewe_excl_dut", cewe_bad[0], 0);
    chk("cewe_excl_ovr", cewe_bad[1], 0);
    chk("addr_data_stable_dut", unstable[0], 0);
    chk("addr_data_stable_ovr", unstable[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
